// File: rtl/uart_rx_mlane.sv
// uart_rx_mlane: multi-lane parallel UART receiver.
// All lanes share one bit clock and move one bit-time per lane in lockstep.
// A frame is a start bit-time (all lanes low), 1..MAX_BITS data bit-times and
// a stop bit-time (all lanes high). Frames are sampled at mid-bit and handed
// to the consumer through a valid/ready holding register.
//
// Ports:
//   CLK          clock
//   nRST         asynchronous active-low reset
//   uart_in      asynchronous serial lanes, NLANES wide
//   len_mask     bit n-1 set = frame with n data bit-times accepted
//   data         held frame; bit-time k at data[k*NLANES +: NLANES]
//   data_len     number of data bit-times in the held frame
//   valid        held frame available
//   ready        consumer takes the held frame when valid && ready
//   frame_err    one-cycle pulse on entry to the error state
//   overrun_err  one-cycle pulse when a good frame is dropped
//   idle         high while waiting for a start bit
module uart_rx_mlane #(
    parameter int unsigned NLANES   = 5,
    parameter int unsigned CLKDIV   = 10,
    parameter int unsigned MAX_BITS = 10
) (
    input  logic                               CLK,
    input  logic                               nRST,
    input  logic [NLANES-1:0]                  uart_in,
    input  logic [MAX_BITS-1:0]                len_mask,
    output logic [MAX_BITS*NLANES-1:0]         data,
    output logic [$clog2(MAX_BITS+1)-1:0]      data_len,
    output logic                               valid,
    input  logic                               ready,
    output logic                               frame_err,
    output logic                               overrun_err,
    output logic                               idle
);

    localparam int unsigned DATA_W = MAX_BITS * NLANES;
    localparam int unsigned LEN_W  = $clog2(MAX_BITS + 1);
    localparam int unsigned DIV_W  = $clog2(CLKDIV);
    localparam int unsigned HALF   = CLKDIV / 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RECV,
        S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [NLANES-1:0]   meta_q, meta_d;
    logic [NLANES-1:0]   sync_q, sync_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [LEN_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [LEN_W-1:0]    data_len_q, data_len_d;
    logic                valid_q, valid_d;
    logic                frame_err_q, frame_err_d;
    logic                overrun_err_q, overrun_err_d;
    logic                idle_q, idle_d;

    logic                all_low;
    logic                all_high;
    logic                div_wrap;
    logic                len_ok;
    logic                commit;

    assign all_low  = ~|sync_q;
    assign all_high = &sync_q;
    assign div_wrap = (div_q == DIV_W'(CLKDIV - 1));

    // Next-state, divider, shadow capture and output register logic
    always_comb begin
        meta_d        = uart_in;
        sync_d        = meta_q;
        state_d       = state_q;
        div_d         = div_wrap ? '0 : div_q + 1'b1;
        bit_cnt_d     = bit_cnt_q;
        shadow_d      = shadow_q;
        data_d        = data_q;
        data_len_d    = data_len_q;
        valid_d       = valid_q;
        frame_err_d   = 1'b0;
        overrun_err_d = 1'b0;
        len_ok        = 1'b0;
        commit        = 1'b0;

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        for (int k = 0; k < int'(MAX_BITS); k++) begin
            if ((int'(bit_cnt_q) == k + 1) && len_mask[k]) begin
                len_ok = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (all_low) begin
                    state_d = S_START;
                    div_d   = '0;
                end
            end
            S_START: begin
                // Half a bit-time in: confirm the start bit at its centre
                if (div_q == DIV_W'(HALF - 1)) begin
                    div_d = '0;
                    if (all_low) begin
                        state_d   = S_RECV;
                        bit_cnt_d = '0;
                        // Cleared here so bit-times beyond the frame read as zero
                        shadow_d  = '0;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_RECV: begin
                if (div_wrap) begin
                    if (all_high) begin
                        if (len_ok) begin
                            commit  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_ERROR;
                            div_d   = '0;
                        end
                    end else if (all_low) begin
                        state_d = S_ERROR;
                        div_d   = '0;
                    end else if (bit_cnt_q == LEN_W'(MAX_BITS)) begin
                        state_d = S_ERROR;
                        div_d   = '0;
                    end else begin
                        for (int k = 0; k < int'(MAX_BITS); k++) begin
                            if (int'(bit_cnt_q) == k) begin
                                shadow_d[k*NLANES +: NLANES] = sync_q;
                            end
                        end
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_ERROR: begin
                // Divider doubles as the run length of consecutive all-high cycles
                if (!all_high) begin
                    div_d = '0;
                end else if (div_wrap) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A frame is loaded only if the holding register is empty or emptying
        if (commit) begin
            if (!valid_q || ready) begin
                data_d     = shadow_q;
                data_len_d = bit_cnt_q;
                valid_d    = 1'b1;
            end else begin
                overrun_err_d = 1'b1;
            end
        end

        frame_err_d = (state_d == S_ERROR) && (state_q != S_ERROR);
        idle_d      = (state_d == S_IDLE);
    end

    // State and output registers. Synchronisers reset to the idle line level
    // so releasing reset never looks like a start bit.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            meta_q        <= '1;
            sync_q        <= '1;
            state_q       <= S_IDLE;
            div_q         <= '0;
            bit_cnt_q     <= '0;
            shadow_q      <= '0;
            data_q        <= '0;
            data_len_q    <= '0;
            valid_q       <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            idle_q        <= 1'b1;
        end else begin
            meta_q        <= meta_d;
            sync_q        <= sync_d;
            state_q       <= state_d;
            div_q         <= div_d;
            bit_cnt_q     <= bit_cnt_d;
            shadow_q      <= shadow_d;
            data_q        <= data_d;
            data_len_q    <= data_len_d;
            valid_q       <= valid_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
            idle_q        <= idle_d;
        end
    end

    assign data        = data_q;
    assign data_len    = data_len_q;
    assign valid       = valid_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
    assign idle        = idle_q;

endmodule

// File: tb/tb_uart_rx_mlane.sv
// tb_uart_rx_mlane: directed bench for uart_rx_mlane (5 lanes, CLKDIV 10,
// up to 10 data bit-times). Accepted lengths are 2, 4 and 10.
module tb_uart_rx_mlane;

    localparam int NL = 5;
    localparam int CD = 10;
    localparam int MB = 10;
    localparam int LW = $clog2(MB + 1);
    localparam int VW = 12 * NL;

    logic              CLK = 1'b0;
    logic              nRST;
    logic [NL-1:0]     uart_in;
    logic [MB-1:0]     len_mask;
    logic [MB*NL-1:0]  data;
    logic [LW-1:0]     data_len;
    logic              valid;
    logic              ready;
    logic              frame_err;
    logic              overrun_err;
    logic              idle;

    int n_pass  = 0;
    int n_total = 0;

    // Event counters, written only by the monitor below
    int               fe_cnt  = 0;
    int               ov_cnt  = 0;
    int               vld_cnt = 0;
    logic [MB*NL-1:0] cap_data = '0;
    logic [LW-1:0]    cap_len  = '0;

    uart_rx_mlane #(
        .NLANES  (NL),
        .CLKDIV  (CD),
        .MAX_BITS(MB)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .uart_in    (uart_in),
        .len_mask   (len_mask),
        .data       (data),
        .data_len   (data_len),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
        .idle       (idle)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        #1;
        if (frame_err)   fe_cnt++;
        if (overrun_err) ov_cnt++;
        if (valid) begin
            vld_cnt++;
            cap_data = data;
            cap_len  = data_len;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle_cycles(input int n);
        uart_in = '1;
        repeat (n) @(negedge CLK);
    endtask

    // Start bit, n data bit-times from v, optional stop bit
    task automatic send_frame(input logic [VW-1:0] v, input int n, input bit stop);
        uart_in = '0;
        repeat (CD) @(negedge CLK);
        for (int k = 0; k < n; k++) begin
            uart_in = v[k*NL +: NL];
            repeat (CD) @(negedge CLK);
        end
        if (stop) begin
            uart_in = '1;
            repeat (CD) @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        nRST     = 1'b0;
        uart_in  = '1;
        ready    = 1'b1;
        len_mask = 10'b10_0000_1010;
        repeat (3) @(negedge CLK);
        n_total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", valid); else n_pass++;
        n_total++; if (data !== '0) $display("FAIL reset_data: got %h want 0", data); else n_pass++;
        n_total++; if (idle !== 1'b1) $display("FAIL reset_idle: got %0b want 1", idle); else n_pass++;
        n_total++; if ({frame_err, overrun_err} !== 2'b00) $display("FAIL reset_errs: got %b want 00", {frame_err, overrun_err}); else n_pass++;
        nRST = 1'b1;
        idle_cycles(5);
        n_total++; if (idle !== 1'b1) $display("FAIL reset_idle_after: got %0b want 1", idle); else n_pass++;
    endtask

    task automatic test_two_bit_frame();
        int fe0, ov0, v0;
        logic [MB*NL-1:0] exp;
        fe0 = fe_cnt; ov0 = ov_cnt; v0 = vld_cnt;
        exp = 50'({5'h0A, 5'h15});
        ready = 1'b1;
        send_frame(60'({5'h0A, 5'h15}), 2, 1'b1);
        idle_cycles(5);
        n_total++; if (vld_cnt - v0 !== 1) $display("FAIL two_bit_valid_cycles: got %0d want 1", vld_cnt - v0); else n_pass++;
        n_total++; if (cap_data !== exp) $display("FAIL two_bit_data: got %h want %h", cap_data, exp); else n_pass++;
        n_total++; if (cap_len !== 4'd2) $display("FAIL two_bit_len: got %0d want 2", cap_len); else n_pass++;
        n_total++; if (fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0) $display("FAIL two_bit_errs: got fe %0d ov %0d want 0 0", fe_cnt - fe0, ov_cnt - ov0); else n_pass++;
        n_total++; if (valid !== 1'b0) $display("FAIL two_bit_valid_low: got %0b want 0", valid); else n_pass++;
    endtask

    task automatic test_max_frame();
        logic [MB*NL-1:0] exp;
        exp = 50'({5'h0A, 5'h09, 5'h08, 5'h07, 5'h06, 5'h05, 5'h04, 5'h03, 5'h02, 5'h01});
        ready = 1'b0;
        send_frame(60'({5'h0A, 5'h09, 5'h08, 5'h07, 5'h06, 5'h05, 5'h04, 5'h03, 5'h02, 5'h01}), 10, 1'b1);
        idle_cycles(3);
        n_total++; if (valid !== 1'b1) $display("FAIL max_valid: got %0b want 1", valid); else n_pass++;
        n_total++; if (data_len !== 4'd10) $display("FAIL max_len: got %0d want 10", data_len); else n_pass++;
        n_total++; if (data !== exp) $display("FAIL max_data: got %h want %h", data, exp); else n_pass++;
        idle_cycles(20);
        n_total++; if (valid !== 1'b1 || data !== exp) $display("FAIL max_hold: got valid %0b data %h want 1 %h", valid, data, exp); else n_pass++;
        ready = 1'b1;
        @(negedge CLK);
        ready = 1'b0;
        n_total++; if (valid !== 1'b0) $display("FAIL max_consume: got %0b want 0", valid); else n_pass++;
        ready = 1'b1;
    endtask

    task automatic test_bad_length();
        int fe0, v0;
        logic [MB*NL-1:0] exp;
        fe0 = fe_cnt; v0 = vld_cnt;
        send_frame(60'({5'h03, 5'h02, 5'h01}), 3, 1'b1);
        n_total++; if (idle !== 1'b0) $display("FAIL badlen_in_error: got idle %0b want 0", idle); else n_pass++;
        idle_cycles(12);
        n_total++; if (fe_cnt - fe0 !== 1) $display("FAIL badlen_frame_err: got %0d want 1", fe_cnt - fe0); else n_pass++;
        n_total++; if (vld_cnt - v0 !== 0) $display("FAIL badlen_no_valid: got %0d want 0", vld_cnt - v0); else n_pass++;
        n_total++; if (idle !== 1'b1) $display("FAIL badlen_recover_idle: got %0b want 1", idle); else n_pass++;
        exp = 50'({5'h1C, 5'h03, 5'h11, 5'h1E});
        v0 = vld_cnt;
        send_frame(60'({5'h1C, 5'h03, 5'h11, 5'h1E}), 4, 1'b1);
        idle_cycles(4);
        n_total++; if (vld_cnt - v0 !== 1 || cap_data !== exp || cap_len !== 4'd4) $display("FAIL badlen_next_frame: got n %0d data %h len %0d want 1 %h 4", vld_cnt - v0, cap_data, cap_len, exp); else n_pass++;
    endtask

    task automatic test_errors();
        int fe0, v0;
        v0 = vld_cnt;
        // Start glitch: lanes low for only 3 cycles
        fe0 = fe_cnt;
        uart_in = '0;
        repeat (3) @(negedge CLK);
        idle_cycles(25);
        n_total++; if (fe_cnt - fe0 !== 1) $display("FAIL glitch_frame_err: got %0d want 1", fe_cnt - fe0); else n_pass++;
        n_total++; if (idle !== 1'b1) $display("FAIL glitch_recover: got %0b want 1", idle); else n_pass++;
        // All-zero data bit-time
        fe0 = fe_cnt;
        send_frame(60'({5'h07, 5'h00, 5'h05}), 3, 1'b1);
        idle_cycles(15);
        n_total++; if (fe_cnt - fe0 !== 1) $display("FAIL zero_bit_frame_err: got %0d want 1", fe_cnt - fe0); else n_pass++;
        // Eleven data bit-times and no stop bit
        fe0 = fe_cnt;
        send_frame(60'({5'h0B, 5'h0A, 5'h09, 5'h08, 5'h07, 5'h06, 5'h05, 5'h04, 5'h03, 5'h02, 5'h01}), 11, 1'b0);
        idle_cycles(15);
        n_total++; if (fe_cnt - fe0 !== 1) $display("FAIL too_long_frame_err: got %0d want 1", fe_cnt - fe0); else n_pass++;
        n_total++; if (vld_cnt - v0 !== 0) $display("FAIL errors_no_valid: got %0d want 0", vld_cnt - v0); else n_pass++;
        n_total++; if (idle !== 1'b1) $display("FAIL too_long_recover: got %0b want 1", idle); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int ov0, fe0;
        logic [MB*NL-1:0] exp;
        ov0 = ov_cnt; fe0 = fe_cnt;
        exp = 50'({5'h0A, 5'h15});
        ready = 1'b0;
        send_frame(60'({5'h0A, 5'h15}), 2, 1'b1);
        idle_cycles(3);
        send_frame(60'({5'h0C, 5'h03}), 2, 1'b1);
        idle_cycles(3);
        n_total++; if (ov_cnt - ov0 !== 1) $display("FAIL overrun_count: got %0d want 1", ov_cnt - ov0); else n_pass++;
        n_total++; if (valid !== 1'b1 || data !== exp || data_len !== 4'd2) $display("FAIL overrun_held: got valid %0b data %h len %0d want 1 %h 2", valid, data, data_len, exp); else n_pass++;
        n_total++; if (fe_cnt - fe0 !== 0) $display("FAIL overrun_no_frame_err: got %0d want 0", fe_cnt - fe0); else n_pass++;
        ready = 1'b1;
        @(negedge CLK);
        n_total++; if (valid !== 1'b0) $display("FAIL overrun_consume: got %0b want 0", valid); else n_pass++;
    endtask

    task automatic test_mid_frame_reset();
        int fe0, v0;
        logic [MB*NL-1:0] exp;
        fe0 = fe_cnt;
        ready = 1'b0;
        send_frame(60'({5'h0A, 5'h15}), 2, 1'b1);
        idle_cycles(3);
        // Abort a new frame halfway through its third data bit-time
        uart_in = '0;       repeat (CD) @(negedge CLK);
        uart_in = 5'h01;    repeat (CD) @(negedge CLK);
        uart_in = 5'h02;    repeat (CD) @(negedge CLK);
        uart_in = 5'h04;    repeat (CD / 2) @(negedge CLK);
        nRST = 1'b0;
        uart_in = '1;
        @(negedge CLK);
        n_total++; if ({valid, data_len} !== '0 || data !== '0) $display("FAIL midrst_outputs: got valid %0b len %0d data %h want 0", valid, data_len, data); else n_pass++;
        n_total++; if (idle !== 1'b1) $display("FAIL midrst_idle: got %0b want 1", idle); else n_pass++;
        repeat (2) @(negedge CLK);
        nRST  = 1'b1;
        ready = 1'b1;
        idle_cycles(5);
        exp = 50'({5'h0F, 5'h18, 5'h06, 5'h13});
        v0 = vld_cnt;
        send_frame(60'({5'h0F, 5'h18, 5'h06, 5'h13}), 4, 1'b1);
        idle_cycles(4);
        n_total++; if (vld_cnt - v0 !== 1 || cap_data !== exp || cap_len !== 4'd4) $display("FAIL midrst_next_frame: got n %0d data %h len %0d want 1 %h 4", vld_cnt - v0, cap_data, cap_len, exp); else n_pass++;
        n_total++; if (fe_cnt - fe0 !== 0) $display("FAIL midrst_no_frame_err: got %0d want 0", fe_cnt - fe0); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_two_bit_frame();
        test_max_frame();
        test_bad_length();
        test_errors();
        test_back_to_back();
        test_mid_frame_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_mlane.md
Name: uart_rx_mlane

Overview:
Parametrised multi-lane parallel UART receiver and the successor to the fixed 5-lane chiplet receiver. All lanes share one bit clock and carry one bit-time per lane in lockstep. A frame is a start bit (all lanes low), a variable number of data bit-times, and a stop bit (all lanes high). It samples at mid-bit, accepts only frame lengths enabled at runtime, and presents frames through a valid/ready holding register with overrun and framing error reporting. It sits between the chiplet PHY pins and the link-layer deframer.

Parameters:
NLANES, 5, number of parallel serial lanes (>=1)
CLKDIV, 10, CLK cycles per bit-time (>=4)
MAX_BITS, 10, maximum data bit-times per frame (>=1)

Ports:
CLK  input  1  clock
nRST  input  1  reset, asynchronous, active-low
uart_in  input  NLANES  asynchronous serial lanes
len_mask  input  MAX_BITS  bit n-1 set = data length n accepted; static while a frame is in flight
data  output  MAX_BITS*NLANES  received frame; bit-time k at data[k*NLANES +: NLANES], lane i at offset i
data_len  output  $clog2(MAX_BITS+1)  number of data bit-times in the held frame
valid  output  1  held frame available
ready  input  1  consumer accepts the held frame when valid && ready
frame_err  output  1  one-cycle pulse on entry to ERROR
overrun_err  output  1  one-cycle pulse when a good frame is dropped
idle  output  1  high in IDLE state

Behaviour:
- Reset: every register clears asynchronously. data=0, data_len=0, valid=0, frame_err=0, overrun_err=0, idle=1, state=IDLE.
- Sync: each lane passes through a 2-flop synchroniser. all_low = every synced lane is 0. all_high = every synced lane is 1.
- Divider: counts 0..CLKDIV-1 and wraps. It is cleared on every state change into START, RECV or ERROR.
- IDLE: on all_low, go to START and clear the divider. Mixed lane levels are ignored.
- START: wait floor(CLKDIV/2) cycles to reach mid-start-bit.
  - Sample all_low: go to RECV with bit_cnt=0 and the divider cleared.
  - Otherwise: go to ERROR.
- RECV: sample once every CLKDIV cycles, at divider wrap (mid-bit).
  - Sample all_high: this is the stop bit, with n=bit_cnt. If n>=1 and len_mask[n-1]=1, COMMIT and go to IDLE. Otherwise go to ERROR.
  - Sample all_low: go to ERROR. An all-zero data bit-time is illegal on this link.
  - Any other sample with bit_cnt==MAX_BITS: go to ERROR, because the frame is too long.
  - Otherwise: write the synced lanes into shadow bit-time bit_cnt, then bit_cnt++.
- COMMIT happens in the same cycle as the stop sample.
  - valid==0, or valid&&ready in that cycle: data/data_len load on the next edge, with unused upper bit-times zeroed, and valid=1.
  - valid&&!ready: the held frame is kept unchanged, the new frame is dropped, and overrun_err pulses for 1 cycle.
- Handshake: valid stays high and data stays stable until the cycle in which valid&&ready; valid then falls on the next edge unless a COMMIT reloads it in that same cycle.
- ERROR: frame_err pulses on the entry cycle only. The block stays in ERROR until all_high holds for CLKDIV consecutive cycles, then goes to IDLE. Any non-all_high cycle restarts that count. A pending valid frame is unaffected.
- Latency: stop sample occurs 2 + floor(CLKDIV/2) + (n+1)*CLKDIV cycles (±1) after the common falling edge. valid rises 1 cycle after the stop sample.
- A shadow register, separate from the output register, holds bit-times while a frame is in flight, so a held frame is never corrupted by reception.
- Reset asserted mid-frame returns the block to IDLE with outputs cleared. No error pulses.

Test Plan:
- NLANES=5, CLKDIV=10, MAX_BITS=10, len_mask=10'b10_0000_1010, ready=1. Send start, data bit-times 5'h15, 5'h0A, then stop -> valid for 1 cycle, data_len=2, data[4:0]=5'h15, data[9:5]=5'h0A, upper bits 0, no errors.
- Send a 10-bit-time frame with bit-times 1..10 (values 5'h01..5'h0A) -> data_len=10, each slice matches, valid high until ready.
- Send a 3-bit-time frame (len_mask bit 2 clear) -> frame_err pulses once, valid stays 0. Hold lanes high for 10 cycles -> idle=1. A next legal frame is received correctly.
- Start glitch where all lanes go low for 3 cycles only -> ERROR, frame_err=1. Data bit-time 5'h00 mid-frame -> ERROR. 11 data bit-times with no stop -> ERROR.
- ready=0, send two legal frames -> first frame held unchanged, overrun_err pulses once at the second stop. Then assert ready -> first frame consumed, valid drops.
- Assert nRST low mid-frame at bit-time 3 -> all outputs 0, idle=1. After release, a full legal frame is received correctly.
